// File: rtl/ram_request_sequencer.sv
// ram_request_sequencer: queues word read/write requests in a small FIFO and
// issues them one at a time to the RAM controller over its
// instruction/latch/ready handshake. Read data returns in request order as
// one-cycle rsp_valid pulses. A controller that never acknowledges a latch is
// treated as done after ACK_TIMEOUT cycles; this is flagged in the sticky
// timeout_err output.
//
// Handshake semantics: a request transfers on any posedge where
// req_valid & req_ready are both 1. req_ready depends only on the registered
// FIFO count, so it never depends on req_valid in the same cycle. rsp_valid has
// no backpressure; the consumer must take every pulse.
//
// dbg_state exposes the FSM state register: 0 IDLE, 1 ISSUE, 2 WAIT_BUSY,
// 3 WAIT_DONE, 4 COMPLETE.
module ram_request_sequencer #(
  parameter int   DEPTH_LOG2  = 2,
  parameter int   ACK_TIMEOUT = 7,
  parameter logic READ        = 1'b0,
  parameter logic WRITE       = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [22:0]           req_addr,
  input  logic [15:0]           req_data,
  output logic                  rsp_valid,
  output logic [15:0]           rsp_data,
  output logic [22:0]           rsp_addr,
  output logic                  ram_instruction,
  output logic                  ram_latch,
  output logic [22:0]           ram_addr,
  output logic [15:0]           ram_wdata,
  input  logic [15:0]           ram_rdata,
  input  logic                  ram_ready,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  timeout_err,
  output logic [2:0]            dbg_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int TW    = $clog2(ACK_TIMEOUT + 1);
  localparam int EW    = 1 + 23 + 16;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_COMPLETE  = 3'd4;

  // FIFO storage and pointers
  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // FSM and command/response registers
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          timeout_q, timeout_d;
  logic          instr_q, instr_d;
  logic [22:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [15:0]   rsp_data_q, rsp_data_d;
  logic [22:0]   rsp_addr_q, rsp_addr_d;

  logic          push;
  logic          pop;
  logic [EW-1:0] head;
  logic          head_write;
  logic [22:0]   head_addr;
  logic [15:0]   head_data;

  // A full FIFO refuses pushes even when the head pops in the same cycle.
  assign req_ready = (count_q != CW'(DEPTH));
  assign push      = req_valid & req_ready;
  // Pop only from IDLE with an idle controller; a push into an empty FIFO
  // therefore issues on the following cycle at the earliest.
  assign pop       = (state_q == S_IDLE) && (count_q != '0) && ram_ready;

  assign head       = mem_q[rd_ptr_q];
  assign head_write = head[EW-1];
  assign head_addr  = head[EW-2:16];
  assign head_data  = head[15:0];

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Command FSM: pop, strobe latch once, wait for the controller, return read data
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    timeout_d   = timeout_q;
    instr_d     = instr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          instr_d = head_write ? WRITE : READ;
          addr_d  = head_addr;
          wdata_d = head_data;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!ram_ready) begin
          state_d = S_WAIT_DONE;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          // Controller never acknowledged: treat the command as done.
          timeout_d = 1'b1;
          state_d   = S_COMPLETE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (ram_ready) state_d = S_COMPLETE;
      end
      S_COMPLETE: begin
        if (instr_q == READ) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = ram_rdata;
          rsp_addr_d  = addr_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO entry storage; contents are don't-care until counted as valid
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {req_write, req_addr, req_data};
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      timer_q     <= '0;
      timeout_q   <= 1'b0;
      instr_q     <= READ;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      timeout_q   <= timeout_d;
      instr_q     <= instr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
    end
  end

  assign ram_latch       = (state_q == S_ISSUE);
  assign ram_instruction = instr_q;
  assign ram_addr        = addr_q;
  assign ram_wdata       = wdata_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign rsp_addr        = rsp_addr_q;
  assign busy            = (count_q != '0) || (state_q != S_IDLE);
  assign fifo_count      = count_q;
  assign timeout_err     = timeout_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_ram_request_sequencer.sv
// Bench for ram_request_sequencer: a behavioural RAM controller answers the
// latch handshake, a reference memory predicts every read response at request
// acceptance time, and a negedge monitor pops the expected queue on each
// rsp_valid pulse.
module tb_ram_request_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [22:0] req_addr;
  logic [15:0] req_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [22:0] rsp_addr;
  logic        ram_instruction;
  logic        ram_latch;
  logic [22:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic        ram_ready;
  logic        busy;
  logic [2:0]  fifo_count;
  logic        timeout_err;
  logic [2:0]  dbg_state;

  ram_request_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_data        (req_data),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .rsp_addr        (rsp_addr),
    .ram_instruction (ram_instruction),
    .ram_latch       (ram_latch),
    .ram_addr        (ram_addr),
    .ram_wdata       (ram_wdata),
    .ram_rdata       (ram_rdata),
    .ram_ready       (ram_ready),
    .busy            (busy),
    .fifo_count      (fifo_count),
    .timeout_err     (timeout_err),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] init_val(input logic [22:0] a);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  logic [15:0] ref_mem [logic [22:0]];
  logic [38:0] exp_q [$];
  int          n_accepted = 0;
  int          n_reads    = 0;

  task automatic model_accept(input logic w, input logic [22:0] a, input logic [15:0] d);
    n_accepted++;
    if (w) begin
      ref_mem[a] = d;
    end else begin
      n_reads++;
      exp_q.push_back({a, ref_mem.exists(a) ? ref_mem[a] : init_val(a)});
    end
  endtask

  // ---------------- behavioural RAM controller ----------------
  logic [15:0] ram_mem [logic [22:0]];
  logic        ctrl_hold  = 1'b0;
  logic        ctrl_noack = 1'b0;
  logic        ctrl_rand  = 1'b0;
  int          ctrl_busy  = 3;

  initial begin
    int bc;
    ram_ready = 1'b1;
    ram_rdata = 16'h0;
    forever begin
      @(posedge clk); #1;
      if (ram_latch && rst_n) begin
        if (ram_instruction) ram_mem[ram_addr] = ram_wdata;
        else ram_rdata = ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : init_val(ram_addr);
        if (!ctrl_noack) begin
          bc = ctrl_rand ? int'($urandom_range(1, 4)) : ctrl_busy;
          @(posedge clk); #1;
          ram_ready = 1'b0;
          repeat (bc) @(posedge clk);
          #1;
          ram_ready = 1'b1;
        end
      end else begin
        ram_ready = !ctrl_hold;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int          rsp_count   = 0;
  int          latch_count = 0;
  logic        instr_log [$];
  logic        prev_latch  = 1'b0;

  always @(negedge clk) begin
    logic [38:0] e;
    if (rst_n) begin
      if (rsp_valid) begin
        rsp_count++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected: got rsp addr=0x%0h data=0x%0h, required no response", rsp_addr, rsp_data);
        end else begin
          e = exp_q.pop_front();
          check("rsp_addr", 64'(rsp_addr), 64'(e[38:16]));
          check("rsp_data", 64'(rsp_data), 64'(e[15:0]));
        end
      end
      if (ram_latch) begin
        latch_count++;
        instr_log.push_back(ram_instruction);
        check("latch_not_consecutive", 64'(prev_latch), 64'(0));
      end
      if (fifo_count == 3'd4) check("full_not_ready", 64'(req_ready), 64'(0));
      prev_latch = ram_latch;
    end else begin
      prev_latch = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_req(input logic w, input logic [22:0] a, input logic [15:0] d);
    bit done = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_data  = d;
    for (int i = 0; i < 400 && !done; i++) begin
      if (req_ready) begin
        @(posedge clk);
        model_accept(w, a, d);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: request addr=0x%0h not accepted, required acceptance", a);
    end
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int quiet = 0;
    for (int i = 0; i < 3000 && quiet < 4; i++) begin
      @(negedge clk);
      if (!busy && ram_ready) quiet++;
      else quiet = 0;
    end
    check({tag, "_idle"}, 64'(quiet >= 4), 64'(1));
    check({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic wait_latch(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (ram_latch) seen = 1'b1;
    end
    check({tag, "_latch_seen"}, 64'(seen), 64'(1));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lc0, rc0, acc0;
    logic        w;
    logic [22:0] a;
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 23'h00_0ABC;
    req_data  = 16'hDEAD;

    // Test 1: reset held 3 cycles with req_valid high
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_fifo_count", 64'(fifo_count), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_latch", 64'(ram_latch), 64'(0));
    check("rst_instr", 64'(ram_instruction), 64'(0));
    check("rst_ram_addr", 64'(ram_addr), 64'(0));
    check("rst_ram_wdata", 64'(ram_wdata), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_data", 64'(rsp_data), 64'(0));
    check("rst_rsp_addr", 64'(rsp_addr), 64'(0));
    check("rst_timeout", 64'(timeout_err), 64'(0));
    check("rst_state_idle", 64'(dbg_state), 64'(0));
    req_valid = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", 64'(req_ready), 64'(1));
    check("post_rst_count", 64'(fifo_count), 64'(0));

    // Test 2: write then read the same address
    ctrl_busy = 3;
    lc0 = latch_count;
    rc0 = rsp_count;
    instr_log.delete();
    push_req(1'b1, 23'h00_0010, 16'h1234);
    push_req(1'b0, 23'h00_0010, 16'h0000);
    wait_idle("wr_rd");
    check("wr_rd_latches", 64'(latch_count - lc0), 64'(2));
    check("wr_rd_log_len", 64'(instr_log.size()), 64'(2));
    if (instr_log.size() == 2) begin
      check("wr_rd_instr0", 64'(instr_log[0]), 64'(1));
      check("wr_rd_instr1", 64'(instr_log[1]), 64'(0));
    end
    check("wr_rd_rsp_count", 64'(rsp_count - rc0), 64'(1));

    // Tests 3 and 6: fill the FIFO while the controller is busy, then release
    @(negedge clk);
    ctrl_hold = 1'b1;
    repeat (2) @(negedge clk);
    rc0  = rsp_count;
    acc0 = n_accepted;
    fork
      begin
        for (int i = 0; i < 6; i++) push_req(1'b0, 23'h00_0100 + 23'(i), 16'h0);
      end
      begin
        bit rdy = 1'b0;
        repeat (12) @(negedge clk);
        check("fill_count", 64'(fifo_count), 64'(4));
        check("fill_req_ready", 64'(req_ready), 64'(0));
        check("fill_accepted", 64'(n_accepted - acc0), 64'(4));
        ctrl_hold = 1'b0;
        for (int i = 0; i < 20 && !rdy; i++) begin
          @(negedge clk);
          if (ram_ready) rdy = 1'b1;
        end
        check("release_seen", 64'(rdy), 64'(1));
        check("full_pop_count", 64'(fifo_count), 64'(4));
        check("full_pop_req_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        check("after_pop_count", 64'(fifo_count), 64'(3));
      end
    join
    wait_idle("fill");
    check("fill_rsp_count", 64'(rsp_count - rc0), 64'(6));
    check("no_timeout_yet", 64'(timeout_err), 64'(0));

    // Test 4: controller ignores the latch, timeout path
    ctrl_noack = 1'b1;
    lc0 = latch_count;
    rc0 = rsp_count;
    fork
      begin
        push_req(1'b1, 23'h00_0020, 16'hBEEF);
        push_req(1'b0, 23'h00_0020, 16'h0000);
      end
      begin
        wait_latch("to");
        repeat (6) @(negedge clk);
        check("timeout_not_early", 64'(timeout_err), 64'(0));
        repeat (3) @(negedge clk);
        check("timeout_set", 64'(timeout_err), 64'(1));
      end
    join
    wait_idle("to");
    check("to_latches", 64'(latch_count - lc0), 64'(2));
    check("to_rsp_count", 64'(rsp_count - rc0), 64'(1));
    check("timeout_sticky", 64'(timeout_err), 64'(1));
    ctrl_noack = 1'b0;

    // Test 5: reset during WAIT_DONE of a read
    ctrl_busy = 10;
    push_req(1'b0, 23'h00_0055, 16'h0);
    wait_latch("mid_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("mid_rst_count", 64'(fifo_count), 64'(0));
    check("mid_rst_latch", 64'(ram_latch), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_timeout_cleared", 64'(timeout_err), 64'(0));

    // Randomized traffic with random controller latency
    ctrl_rand = 1'b1;
    rc0 = rsp_count;
    n_reads = 0;
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = 23'h7F_FFF8 + 23'($urandom_range(0, 7));
      else a = 23'($urandom_range(0, 7));
      push_req(w, a, 16'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle("rand");
    check("rand_rsp_count", 64'(rsp_count - rc0), 64'(n_reads));
    check("rand_no_timeout", 64'(timeout_err), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
